// File: rtl/kvs_sa_pkg.sv
// rtl/kvs_sa_pkg.sv - shared state type and record layout for kvs_search_and_add_v2
package kvs_sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_INS_SRCH,
        ST_INS_WS,
        ST_INS_UPD,
        ST_INS_WU,
        ST_DONE
    } state_t;

    localparam int DROP_W = 16;

    // Records are packed {weight, value, key} with the key in the low bits.
    function automatic int key_lsb();
        return 0;
    endfunction

    function automatic int val_lsb(input int key_w);
        return key_w;
    endfunction

    function automatic int cnt_lsb(input int key_w, input int val_w);
        return key_w + val_w;
    endfunction

endpackage

// File: rtl/sync_fifo_ft.sv
// rtl/sync_fifo_ft.sv - first-word-fall-through synchronous FIFO with programmable-full flag
module sync_fifo_ft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     xreset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     we,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    input  logic                     re,
    output logic                     full,
    output logic                     prog_full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    assign count     = wr_ptr - rd_ptr;
    assign valid     = count != '0;
    assign full      = count == (AW+1)'(DEPTH);
    assign prog_full = count >= (AW+1)'(DEPTH - 2);
    assign dout      = mem[rd_ptr[AW-1:0]];
    assign push      = we && !full;
    assign pop       = re && valid;

    always_ff @(posedge clk) begin
        if (!xreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!xreset) !(we && full));

endmodule

// File: rtl/kvs_search_and_add_v2.sv
// rtl/kvs_search_and_add_v2.sv - pipelined KVS search with parked-miss insert and weighted accumulate
module kvs_search_and_add_v2
    import kvs_sa_pkg::*;
#(
    parameter int KEY_W      = 128,
    parameter int VAL_W      = 32,
    parameter int CNT_W      = 32,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_OUT    = 8
) (
    input  logic                         clk,
    input  logic                         xreset,
    output logic                         ready,
    input  logic                         kick,
    output logic                         busy,
    output logic                         done,
    input  logic [CNT_W+VAL_W+KEY_W-1:0] din,
    input  logic                         we,
    output logic                         full,
    output logic [ADDR_W-1:0]            accum_addr,
    output logic [VAL_W+CNT_W-1:0]       accum_din,
    output logic                         accum_we,
    output logic [DROP_W-1:0]            drop_count,
    output logic                         kvs_cmd_valid,
    output logic                         kvs_cmd_search,
    output logic                         kvs_cmd_update,
    output logic [KEY_W-1:0]             kvs_key,
    output logic [VAL_W-1:0]             kvs_value,
    input  logic                         kvs_ready,
    input  logic                         kvs_ack,
    input  logic                         kvs_hit,
    input  logic [ADDR_W-1:0]            kvs_ent_addr,
    input  logic [ADDR_W-1:0]            kvs_ient_add,
    input  logic                         kvs_ent_full
);

    localparam int REC_W   = CNT_W + VAL_W + KEY_W;
    localparam int KEY_LSB = key_lsb();
    localparam int VAL_LSB = val_lsb(KEY_W);
    localparam int CNT_LSB = cnt_lsb(KEY_W, VAL_W);
    localparam int OUT_W   = $clog2(MAX_OUT + 1);
    localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

    state_t state, nxt;
    logic [OUT_W-1:0] outstanding;

    logic [REC_W-1:0] in_dout, chk_dout, rest_dout;
    logic in_valid, chk_valid, rest_valid;
    logic in_re, chk_we, chk_re, rest_we, rest_re;
    logic in_full, chk_full, chk_pfull, rest_full, rest_pfull;
    logic [FCW-1:0] in_count, chk_count, rest_count;

    logic issue, stream_ack, start, drop_inc;
    logic cmd_search_c, cmd_update_c, acc_we_c;
    logic [KEY_W-1:0] cmd_key_c;
    logic [VAL_W-1:0] cmd_val_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [VAL_W+CNT_W-1:0] acc_din_c;
    state_t ins_next;

    logic [KEY_W-1:0] in_key, rest_key;
    logic [VAL_W-1:0] in_val, chk_val, rest_val;
    logic [CNT_W-1:0] chk_cnt, rest_cnt;

    assign in_key   = in_dout[KEY_LSB +: KEY_W];
    assign in_val   = in_dout[VAL_LSB +: VAL_W];
    assign chk_val  = chk_dout[VAL_LSB +: VAL_W];
    assign chk_cnt  = chk_dout[CNT_LSB +: CNT_W];
    assign rest_key = rest_dout[KEY_LSB +: KEY_W];
    assign rest_val = rest_dout[VAL_LSB +: VAL_W];
    assign rest_cnt = rest_dout[CNT_LSB +: CNT_W];

    logic unused_ok;
    assign unused_ok = &{1'b0, in_full, chk_full, chk_pfull, rest_full, rest_pfull,
                         in_count, chk_count, in_dout[CNT_LSB +: CNT_W], chk_dout[KEY_LSB +: KEY_W]};

    assign ready    = kvs_ready;
    assign busy     = (state != ST_IDLE) && (state != ST_DONE);
    assign done     = state == ST_DONE;
    assign ins_next = (rest_count == FCW'(1)) ? ST_DONE : ST_INS_SRCH;

    sync_fifo_ft #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(clk), .xreset(xreset), .din(din), .we(we), .dout(in_dout), .valid(in_valid),
        .re(in_re), .full(in_full), .prog_full(full), .count(in_count));

    sync_fifo_ft #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_chk_fifo (
        .clk(clk), .xreset(xreset), .din(in_dout), .we(chk_we), .dout(chk_dout), .valid(chk_valid),
        .re(chk_re), .full(chk_full), .prog_full(chk_pfull), .count(chk_count));

    sync_fifo_ft #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_rest_fifo (
        .clk(clk), .xreset(xreset), .din(chk_dout), .we(rest_we), .dout(rest_dout), .valid(rest_valid),
        .re(rest_re), .full(rest_full), .prog_full(rest_pfull), .count(rest_count));

    always_ff @(posedge clk) begin
        if (!xreset) state <= ST_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt          = state;
        issue        = 1'b0;
        stream_ack   = 1'b0;
        start        = 1'b0;
        drop_inc     = 1'b0;
        in_re        = 1'b0;
        chk_we       = 1'b0;
        chk_re       = 1'b0;
        rest_we      = 1'b0;
        rest_re      = 1'b0;
        cmd_search_c = 1'b0;
        cmd_update_c = 1'b0;
        cmd_key_c    = '0;
        cmd_val_c    = '0;
        acc_we_c     = 1'b0;
        acc_addr_c   = '0;
        acc_din_c    = '0;
        case (state)
            ST_IDLE: begin
                if (kick && kvs_ready) begin
                    start = 1'b1;
                    nxt   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (in_valid && outstanding < OUT_W'(MAX_OUT)) begin
                    issue        = 1'b1;
                    in_re        = 1'b1;
                    chk_we       = 1'b1;
                    cmd_search_c = 1'b1;
                    cmd_key_c    = in_key;
                    cmd_val_c    = in_val;
                end
                // A response with nothing in the check FIFO cannot belong to this batch.
                if (kvs_ack && chk_valid) begin
                    stream_ack = 1'b1;
                    chk_re     = 1'b1;
                    if (kvs_hit) begin
                        acc_we_c   = 1'b1;
                        acc_addr_c = kvs_ent_addr;
                        acc_din_c  = {chk_val, chk_cnt};
                    end else begin
                        rest_we = 1'b1;
                    end
                end
                if (!in_valid && outstanding == '0) nxt = ST_DRAIN;
            end
            ST_DRAIN: nxt = rest_valid ? ST_INS_SRCH : ST_DONE;
            ST_INS_SRCH: begin
                cmd_search_c = 1'b1;
                cmd_key_c    = rest_key;
                cmd_val_c    = rest_val;
                nxt          = ST_INS_WS;
            end
            ST_INS_WS: begin
                if (kvs_ack) begin
                    if (kvs_hit) begin
                        acc_we_c   = 1'b1;
                        acc_addr_c = kvs_ent_addr;
                        acc_din_c  = {rest_val, rest_cnt};
                        rest_re    = 1'b1;
                        nxt        = ins_next;
                    end else if (kvs_ent_full) begin
                        drop_inc = 1'b1;
                        rest_re  = 1'b1;
                        nxt      = ins_next;
                    end else begin
                        nxt = ST_INS_UPD;
                    end
                end
            end
            ST_INS_UPD: begin
                cmd_update_c = 1'b1;
                cmd_key_c    = rest_key;
                cmd_val_c    = rest_val;
                nxt          = ST_INS_WU;
            end
            ST_INS_WU: begin
                if (kvs_ack) begin
                    acc_we_c   = 1'b1;
                    acc_addr_c = kvs_ient_add;
                    acc_din_c  = {rest_val, rest_cnt};
                    rest_re    = 1'b1;
                    nxt        = ins_next;
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xreset) begin
            accum_we       <= 1'b0;
            accum_addr     <= '0;
            accum_din      <= '0;
            kvs_cmd_valid  <= 1'b0;
            kvs_cmd_search <= 1'b0;
            kvs_cmd_update <= 1'b0;
            kvs_key        <= '0;
            kvs_value      <= '0;
            drop_count     <= '0;
            outstanding    <= '0;
        end else begin
            accum_we <= acc_we_c;
            if (acc_we_c) begin
                accum_addr <= acc_addr_c;
                accum_din  <= acc_din_c;
            end
            kvs_cmd_valid  <= cmd_search_c | cmd_update_c;
            kvs_cmd_search <= cmd_search_c;
            kvs_cmd_update <= cmd_update_c;
            if (cmd_search_c | cmd_update_c) begin
                kvs_key   <= cmd_key_c;
                kvs_value <= cmd_val_c;
            end
            if (start) begin
                drop_count  <= '0;
                outstanding <= '0;
            end else begin
                if (drop_inc && drop_count != '1) drop_count <= drop_count + 1'b1;
                case ({issue, stream_ack})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kvs_search_and_add_v2.sv
// tb/tb_kvs_search_and_add_v2.sv - randomized self-checking bench with a behavioural KVS and reference model
module tb_kvs_search_and_add_v2;

    localparam int KEY_W = 16, VAL_W = 8, CNT_W = 8, ADDR_W = 8, FIFO_DEPTH = 8, MAX_OUT = 3;

    logic clk = 1'b0;
    logic xreset = 1'b0;
    logic ready, kick = 1'b0, busy, done, we = 1'b0, full, accum_we;
    logic [CNT_W+VAL_W+KEY_W-1:0] din = '0;
    logic [ADDR_W-1:0] accum_addr;
    logic [VAL_W+CNT_W-1:0] accum_din;
    logic [15:0] drop_count;
    logic kvs_cmd_valid, kvs_cmd_search, kvs_cmd_update;
    logic [KEY_W-1:0] kvs_key;
    logic [VAL_W-1:0] kvs_value;
    logic kvs_ready = 1'b1, kvs_ack = 1'b0, kvs_hit = 1'b0, kvs_ent_full = 1'b0;
    logic [ADDR_W-1:0] kvs_ent_addr = '0, kvs_ient_add = '0;

    always #5 clk = ~clk;

    kvs_search_and_add_v2 #(
        .KEY_W(KEY_W), .VAL_W(VAL_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .xreset(xreset), .ready(ready), .kick(kick), .busy(busy), .done(done),
        .din(din), .we(we), .full(full), .accum_addr(accum_addr), .accum_din(accum_din),
        .accum_we(accum_we), .drop_count(drop_count), .kvs_cmd_valid(kvs_cmd_valid),
        .kvs_cmd_search(kvs_cmd_search), .kvs_cmd_update(kvs_cmd_update), .kvs_key(kvs_key),
        .kvs_value(kvs_value), .kvs_ready(kvs_ready), .kvs_ack(kvs_ack), .kvs_hit(kvs_hit),
        .kvs_ent_addr(kvs_ent_addr), .kvs_ient_add(kvs_ient_add), .kvs_ent_full(kvs_ent_full)
    );

    typedef struct {
        int         due;
        logic       hit;
        logic [7:0] addr;
        logic [7:0] iaddr;
    } rsp_t;

    rsp_t rsp_q[$];
    int tbl[int];
    int next_addr = 0;
    int lat_cfg = 1;
    int cyc = 0, cmds = 0, acks = 0, n_upd = 0, n_done = 0, max_if = 0;
    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    int rk[$], rv[$], rw[$];
    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural KVS: in-order responses after lat_cfg cycles, plus output monitors.
    always @(negedge clk) begin : kvs_model
        rsp_t r;
        cyc++;
        kvs_ack = 1'b0;
        kvs_hit = 1'b0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            kvs_ack      = 1'b1;
            kvs_hit      = r.hit;
            kvs_ent_addr = r.addr;
            kvs_ient_add = r.iaddr;
            acks++;
        end
        if (kvs_cmd_valid) begin
            r.due = cyc + lat_cfg;
            r.hit = 1'b0;
            r.addr = '0;
            r.iaddr = '0;
            if (kvs_cmd_search && tbl.exists(int'(kvs_key))) begin
                r.hit  = 1'b1;
                r.addr = 8'(tbl[int'(kvs_key)]);
            end
            if (kvs_cmd_update) begin
                tbl[int'(kvs_key)] = next_addr;
                r.iaddr = 8'(next_addr);
                next_addr++;
                n_upd++;
            end
            rsp_q.push_back(r);
            cmds++;
        end
        if (cmds - acks > max_if) max_if = cmds - acks;
        if (accum_we) obs_q.push_back({accum_addr, accum_din});
        if (done) n_done++;
    end

    task automatic run_batch(input string tag, input bit efull);
        int ref_tbl[int];
        int mq[$];
        int na, drops, upds, idx, budget;
        bit kicked;
        ref_tbl = tbl;
        na = next_addr;
        drops = 0;
        upds = 0;
        exp_q.delete();
        foreach (rk[i]) begin
            if (ref_tbl.exists(rk[i])) exp_q.push_back({8'(ref_tbl[rk[i]]), 8'(rv[i]), 8'(rw[i])});
            else mq.push_back(i);
        end
        foreach (mq[j]) begin
            int i;
            i = mq[j];
            if (ref_tbl.exists(rk[i])) begin
                exp_q.push_back({8'(ref_tbl[rk[i]]), 8'(rv[i]), 8'(rw[i])});
            end else if (efull) begin
                drops++;
            end else begin
                ref_tbl[rk[i]] = na;
                exp_q.push_back({8'(na), 8'(rv[i]), 8'(rw[i])});
                na++;
                upds++;
            end
        end
        @(negedge clk);
        kvs_ent_full = efull;
        obs_q.delete();
        n_upd = 0;
        n_done = 0;
        max_if = 0;
        idx = 0;
        kicked = 0;
        budget = 0;
        while (n_done == 0 && budget < 3000) begin
            @(negedge clk);
            kick = 1'b0;
            we = 1'b0;
            if (idx < rk.size() && !full) begin
                din = {8'(rw[idx]), 8'(rv[idx]), 16'(rk[idx])};
                we = 1'b1;
                idx++;
            end else if (!kicked) begin
                kick = 1'b1;
                kicked = 1;
            end
            budget++;
        end
        @(negedge clk);
        kick = 1'b0;
        we = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " done_seen"}, 32'(n_done), 32'd1);
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
        chk({tag, " n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) chk($sformatf("%s write%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        chk({tag, " updates"}, 32'(n_upd), 32'(upds));
        chk({tag, " drop_count"}, 32'(drop_count), 32'(drops));
        chk({tag, " max_inflight_ok"}, 32'(max_if <= MAX_OUT), 32'd1);
    endtask

    initial begin : main
        int n0, budget, nw;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst accum_we", 32'(accum_we), 0);
        chk("rst accum_addr", 32'(accum_addr), 0);
        chk("rst accum_din", 32'(accum_din), 0);
        chk("rst cmd_valid", 32'(kvs_cmd_valid), 0);
        chk("rst kvs_key", 32'(kvs_key), 0);
        chk("rst kvs_value", 32'(kvs_value), 0);
        chk("rst drop_count", 32'(drop_count), 0);
        chk("rst full", 32'(full), 0);
        chk("ready follows kvs_ready", 32'(ready), 1);
        xreset = 1'b1;

        tbl.delete(); tbl[16'hA] = 5; next_addr = 0; lat_cfg = 1;
        rk = '{16'hA}; rv = '{7}; rw = '{3};
        run_batch("t1_hit", 0);

        tbl.delete(); next_addr = 0; lat_cfg = 2;
        rk = '{16'hB, 16'hB, 16'hB}; rv = '{9, 9, 9}; rw = '{1, 1, 1};
        run_batch("t2_dup_insert", 0);

        for (int b = 0; b < 4; b++) begin
            tbl.delete(); next_addr = 20;
            for (int k = 1; k <= 3; k++) tbl[k] = 10 + k;
            lat_cfg = (b == 0) ? 4 : int'($urandom_range(1, 6));
            rk.delete(); rv.delete(); rw.delete();
            for (int i = 0; i < 10; i++) begin
                rk.push_back(int'($urandom_range(1, (b == 0) ? 3 : 6)));
                rv.push_back(int'($urandom_range(0, 255)));
                rw.push_back(int'($urandom_range(0, 255)));
            end
            run_batch($sformatf("t3_rand%0d", b), 0);
        end

        tbl.delete(); next_addr = 0; lat_cfg = 1;
        rk = '{16'h40, 16'h41}; rv = '{1, 2}; rw = '{5, 6};
        run_batch("t4_full", 1);
        kvs_ent_full = 1'b0;

        tbl.delete();
        for (int k = 1; k <= 3; k++) tbl[k] = 10 + k;
        lat_cfg = 20;
        @(negedge clk);
        obs_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din = {8'(i), 8'(i + 1), 16'(1 + i % 3)};
            we = 1'b1;
        end
        @(negedge clk);
        we = 1'b0;
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        budget = 0;
        while (cmds - acks < 3 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("t5 inflight3", 32'(cmds - acks), 32'd3);
        xreset = 1'b0;
        @(negedge clk);
        chk("t5 busy_after_reset", 32'(busy), 0);
        chk("t5 cmd_after_reset", 32'(kvs_cmd_valid), 0);
        chk("t5 drop_after_reset", 32'(drop_count), 0);
        xreset = 1'b1;
        n0 = cmds;
        nw = obs_q.size();
        repeat (40) @(negedge clk);
        chk("t5 late_ack_writes", 32'(obs_q.size() - nw), 0);
        chk("t5 no_cmds_after_reset", 32'(cmds - n0), 0);
        chk("t5 late_acks_drained", 32'(rsp_q.size()), 0);
        lat_cfg = 2;
        rk = '{1, 2}; rv = '{33, 44}; rw = '{3, 4};
        run_batch("t5_clean", 0);

        kvs_ready = 1'b0;
        @(negedge clk);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        n0 = cmds;
        repeat (10) @(negedge clk);
        chk("t6 busy_not_ready", 32'(busy), 0);
        chk("t6 ready_low", 32'(ready), 0);
        chk("t6 no_cmds", 32'(cmds - n0), 0);
        kvs_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
